// File: rtl/udsp_frame_sequencer.sv
// Per-sample frame controller: starts the uDSP core on each sample tick and arbitrates data-memory writes.
// Optional saturating dropped-tick counter is built when UDSP_SEQ_OVERRUN_CNT_EN is defined.
module udsp_frame_sequencer #(
    parameter int DAW        = 10,
    parameter int DWW        = 36,
    parameter int PROG_LEN   = 512,
    parameter int PIPE_DEPTH = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_tick,
    output logic            dsp_start,
    input  logic [DAW-1:0]  dsp_addrW,
    input  logic [DWW-1:0]  dsp_dataW,
    input  logic            dsp_writeEn,
    input  logic            host_valid,
    output logic            host_ready,
    input  logic [DAW-1:0]  host_addr,
    input  logic [DWW-1:0]  host_data,
    output logic [DAW-1:0]  mem_addrW,
    output logic [DWW-1:0]  mem_dataW,
    output logic            mem_writeEn,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun,
    input  logic            overrun_clr,
    output logic [15:0]     overrun_count
);

    localparam int RUN_LEN = PROG_LEN + PIPE_DEPTH;
    localparam int CW      = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] run_cnt;
    logic          dropped;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = START;
            START:   state_next = RUN;
            RUN:     if (run_cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign dropped    = sample_tick && (state != IDLE);
    assign host_ready = (state == IDLE) && !sample_tick;

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            run_cnt    <= '0;
            dsp_start  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            dsp_start  <= (state_next == START);
            frame_done <= (state_next == DONE);
            busy       <= (state_next != IDLE);
            if (state == START) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (dropped) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Core writes are gated by reset so an aborted frame cannot write in the reset cycle.
    always_comb begin
        mem_writeEn = 1'b0;
        mem_addrW   = dsp_addrW;
        mem_dataW   = dsp_dataW;
        if (state == RUN) begin
            mem_writeEn = dsp_writeEn && !reset;
        end else if (host_valid && host_ready) begin
            mem_writeEn = 1'b1;
            mem_addrW   = host_addr;
            mem_dataW   = host_data;
        end
    end

`ifdef UDSP_SEQ_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_count <= '0;
        end else if (dropped && overrun_clr) begin
            overrun_count <= 16'd1;
        end else if (overrun_clr) begin
            overrun_count <= '0;
        end else if (dropped && (overrun_count != 16'hFFFF)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end
`else
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_udsp_frame_sequencer.sv
// Self-checking bench for udsp_frame_sequencer: timing-offset reference model plus directed literal checks.
module tb_udsp_frame_sequencer;

    localparam int DAW        = 10;
    localparam int DWW        = 36;
    localparam int PROG_LEN   = 512;
    localparam int PIPE_DEPTH = 3;
    localparam int RUN_LEN    = PROG_LEN + PIPE_DEPTH;
`ifdef UDSP_SEQ_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic           sample_tick;
    logic           dsp_start;
    logic [DAW-1:0] dsp_addrW;
    logic [DWW-1:0] dsp_dataW;
    logic           dsp_writeEn;
    logic           host_valid;
    logic           host_ready;
    logic [DAW-1:0] host_addr;
    logic [DWW-1:0] host_data;
    logic [DAW-1:0] mem_addrW;
    logic [DWW-1:0] mem_dataW;
    logic           mem_writeEn;
    logic           busy;
    logic           frame_done;
    logic           overrun;
    logic           overrun_clr;
    logic [15:0]    overrun_count;

    udsp_frame_sequencer #(
        .DAW(DAW), .DWW(DWW), .PROG_LEN(PROG_LEN), .PIPE_DEPTH(PIPE_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .dsp_start(dsp_start),
        .dsp_addrW(dsp_addrW), .dsp_dataW(dsp_dataW), .dsp_writeEn(dsp_writeEn),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .mem_addrW(mem_addrW), .mem_dataW(mem_dataW),
        .mem_writeEn(mem_writeEn), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .overrun_clr(overrun_clr), .overrun_count(overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    bit chk_en = 1'b0;
    int total  = 0;
    int passed = 0;

    // Model: a frame is the RUN_LEN+3 cycles following an accepted tick at cycle m_t0.
    bit m_active = 1'b0;
    int m_t0     = 0;
    bit m_ov     = 1'b0;
    int m_cnt    = 0;

    function automatic bit m_idle(input int c);
        return !m_active || ((c - m_t0) >= RUN_LEN + 3);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_ov     = 1'b0;
            m_cnt    = 0;
        end else begin
            if (sample_tick && !m_idle(cyc)) begin
                m_ov  = 1'b1;
                m_cnt = overrun_clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
            end else if (overrun_clr) begin
                m_ov  = 1'b0;
                m_cnt = 0;
            end
            if (sample_tick && m_idle(cyc)) begin
                m_active = 1'b1;
                m_t0     = cyc;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int  p;
            bit  act, e_run, e_ready, e_we;
            logic [DAW-1:0] e_addr;
            logic [DWW-1:0] e_data;
            p       = cyc - m_t0;
            act     = m_active && (p < RUN_LEN + 3);
            e_run   = act && (p >= 2) && (p <= RUN_LEN + 1);
            e_ready = !act && !sample_tick;
            e_we    = (e_run && !reset) ? dsp_writeEn : (e_ready && host_valid);
            e_addr  = e_run ? dsp_addrW : host_addr;
            e_data  = e_run ? dsp_dataW : host_data;
            check("dsp_start",  64'(dsp_start),  64'(act && p == 1));
            check("busy",       64'(busy),       64'(act && p >= 1 && p <= RUN_LEN + 2));
            check("frame_done", 64'(frame_done), 64'(act && p == RUN_LEN + 2));
            check("host_ready", 64'(host_ready), 64'(e_ready));
            check("mem_we",     64'(mem_writeEn), 64'(e_we));
            check("overrun",    64'(overrun),    64'(m_ov));
            check("ov_count",   64'(overrun_count), CNT_EN ? 64'(m_cnt) : 64'd0);
            if (e_we) begin
                check("mem_addr", 64'(mem_addrW), 64'(e_addr));
                check("mem_data", 64'(mem_dataW), 64'(e_data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        dsp_addrW = DAW'(cyc);
        dsp_dataW = DWW'(64'(cyc) * 64'd977 + 64'h5_0000_0000);
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic pulse_clr();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; dsp_writeEn = 1'b1;
        dsp_addrW = '0; dsp_dataW = '0;
        host_valid = 1'b0; host_addr = '0; host_data = '0; overrun_clr = 1'b0;
        step();
        chk_en = 1'b1;
        goto(3);
        reset = 1'b0;
        @(negedge clk);
        check("lit_ready_after_reset", 64'(host_ready), 64'd1);
        check("lit_busy_after_reset", 64'(busy), 64'd0);

        // Host write while parked
        goto(5);
        host_valid = 1'b1; host_addr = 10'h005; host_data = 36'h123456789;
        @(negedge clk);
        check("lit_host_we", 64'(mem_writeEn), 64'd1);
        check("lit_host_addr", 64'(mem_addrW), 64'h005);
        check("lit_host_data", 64'(mem_dataW), 64'h123456789);
        check("lit_host_ready", 64'(host_ready), 64'd1);
        step();
        host_valid = 1'b0;

        // Frame 1: tick at 10
        goto(10);
        pulse_tick();
        @(negedge clk);
        check("lit_start_11", 64'(dsp_start), 64'd1);
        check("lit_busy_11", 64'(busy), 64'd1);
        goto(12);
        @(negedge clk);
        check("lit_we_12", 64'(mem_writeEn), 64'd1);
        goto(100);
        host_valid = 1'b1; host_addr = 10'h007; dsp_writeEn = 1'b0;
        @(negedge clk);
        check("lit_ready_run", 64'(host_ready), 64'd0);
        check("lit_no_write_run", 64'(mem_writeEn), 64'd0);
        step();
        host_valid = 1'b0; dsp_writeEn = 1'b1;
        goto(526);
        @(negedge clk);
        check("lit_we_526", 64'(mem_writeEn), 64'd1);
        goto(527);
        @(negedge clk);
        check("lit_done_527", 64'(frame_done), 64'd1);
        check("lit_we_done", 64'(mem_writeEn), 64'd0);
        goto(528);
        @(negedge clk);
        check("lit_busy_528", 64'(busy), 64'd0);
        check("lit_done_528", 64'(frame_done), 64'd0);
        check("lit_we_idle", 64'(mem_writeEn), 64'd0);

        // Frame 2: tick and host request collide; one dropped tick
        goto(600);
        sample_tick = 1'b1; host_valid = 1'b1; host_addr = 10'h02A; host_data = 36'hABCDE0123;
        @(negedge clk);
        check("lit_ready_tick", 64'(host_ready), 64'd0);
        check("lit_we_tick", 64'(mem_writeEn), 64'd0);
        step();
        sample_tick = 1'b0;
        @(negedge clk);
        check("lit_start_601", 64'(dsp_start), 64'd1);
        goto(700);
        pulse_tick();
        @(negedge clk);
        check("lit_overrun_701", 64'(overrun), 64'd1);
        check("lit_count_701", 64'(overrun_count), CNT_EN ? 64'd1 : 64'd0);
        goto(1117);
        @(negedge clk);
        check("lit_done_1117", 64'(frame_done), 64'd1);
        goto(1118);
        @(negedge clk);
        check("lit_host_after", 64'(mem_writeEn), 64'd1);
        check("lit_host_after_addr", 64'(mem_addrW), 64'h02A);
        step();
        host_valid = 1'b0;
        goto(1150);
        pulse_clr();
        @(negedge clk);
        check("lit_clr_1151", 64'(overrun), 64'd0);

        // Frame 3: three drops, clear, then drop+clear together
        goto(1200); pulse_tick();
        goto(1300); pulse_tick();
        goto(1310); pulse_tick();
        goto(1320); pulse_tick();
        @(negedge clk);
        check("lit_count_3", 64'(overrun_count), CNT_EN ? 64'd3 : 64'd0);
        goto(1330); pulse_clr();
        @(negedge clk);
        check("lit_clr_ov", 64'(overrun), 64'd0);
        check("lit_clr_cnt", 64'(overrun_count), 64'd0);
        goto(1340);
        sample_tick = 1'b1; overrun_clr = 1'b1;
        step();
        sample_tick = 1'b0; overrun_clr = 1'b0;
        @(negedge clk);
        check("lit_set_wins", 64'(overrun), 64'd1);
        check("lit_set_wins_cnt", 64'(overrun_count), CNT_EN ? 64'd1 : 64'd0);
        goto(1350); pulse_clr();
        goto(1717);
        @(negedge clk);
        check("lit_done_1717", 64'(frame_done), 64'd1);

        // Frame 4: reset aborts mid-run
        goto(1800); pulse_tick();
        goto(2001);
        reset = 1'b1;
        @(negedge clk);
        check("lit_we_in_reset", 64'(mem_writeEn), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("lit_busy_abort", 64'(busy), 64'd0);
        check("lit_done_abort", 64'(frame_done), 64'd0);
        goto(2003); pulse_tick();
        @(negedge clk);
        check("lit_start_2004", 64'(dsp_start), 64'd1);
        goto(2520);
        @(negedge clk);
        check("lit_done_2520", 64'(frame_done), 64'd1);

        // Frame 5: ticks in START and DONE dropped, tick on return to IDLE accepted
        goto(2600); pulse_tick();
        pulse_tick();
        goto(3117);
        sample_tick = 1'b1;
        @(negedge clk);
        check("lit_done_3117", 64'(frame_done), 64'd1);
        step();
        step();
        sample_tick = 1'b0;
        @(negedge clk);
        check("lit_start_3119", 64'(dsp_start), 64'd1);
        goto(3700);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
